// File: rtl/fwd_lkp_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_lkp_engine_pkg
//  Brief    : Shared types, widths and helpers for the forwarding lookup engine
//  Revision : 1.0
// ============================================================================
package fwd_lkp_engine_pkg;

  // Field widths that do not depend on the channel count
  localparam int TAG_W = 12;
  localparam int KEY_W = 8;
  localparam int CNT_W = 16;

  // Tag occupies the low bits of a table entry; the mask sits directly above it
  localparam int FWD_TAG_MSB = TAG_W - 1;

  // Lookup sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // MSB of the mask field for a given channel count
  function automatic int fwd_mask_msb(input int channel_num);
    return TAG_W + channel_num - 1;
  endfunction

  // Statistics counters stick at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_lkp_engine_res_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_res_fifo
//  Brief    : Synchronous first-word-fall-through result FIFO
//  Revision : 1.0
// ============================================================================
module fwd_res_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO may still accept a push
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != c_FULL_CNT) || w_do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_valid = (r_count != '0);
  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fwd_lkp_engine.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_lkp_engine
//  Brief    : Descriptor-driven forwarding table client; queues hits, drops
//             and counts misses
//  Revision : 1.0
// ============================================================================
module fwd_lkp_engine
  import fwd_lkp_engine_pkg::*;
#(
  parameter int CHANNEL_NUM = 4,
  parameter int ID_W        = 8,
  parameter int LKP_LAT     = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_pkt_valid,
  output logic                       o_pkt_ready,
  input  logic [KEY_W-1:0]           i_pkt_key,
  input  logic [ID_W-1:0]            i_pkt_id,
  output logic                       o_fwd_rden,
  output logic [KEY_W-1:0]           o_fwd_addr,
  input  logic [TAG_W+CHANNEL_NUM-1:0] i_fwd_data,
  output logic                       o_res_valid,
  input  logic                       i_res_ready,
  output logic [ID_W-1:0]            o_res_id,
  output logic [CHANNEL_NUM-1:0]     o_res_mask,
  output logic [TAG_W-1:0]           o_res_tag,
  output logic [CNT_W-1:0]           o_hit_cnt,
  output logic [CNT_W-1:0]           o_drop_cnt
);

  localparam int c_MASK_MSB = fwd_mask_msb(CHANNEL_NUM);
  localparam int c_RES_W    = ID_W + CHANNEL_NUM + TAG_W;
  localparam int c_FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int c_LAT_W    = (LKP_LAT > 1) ? $clog2(LKP_LAT) : 1;
  localparam logic [c_FCNT_W-1:0] c_FIFO_FULL = c_FCNT_W'(FIFO_DEPTH);
  localparam logic [c_LAT_W-1:0]  c_LAT_LOAD  = c_LAT_W'(LKP_LAT - 1);

  state_t               r_state;
  logic                 r_rdy_en;
  logic                 r_fwd_rden;
  logic [KEY_W-1:0]     r_fwd_addr;
  logic [ID_W-1:0]      r_id;
  logic [c_LAT_W-1:0]   r_lat_cnt;
  logic [CNT_W-1:0]     r_hit_cnt;
  logic [CNT_W-1:0]     r_drop_cnt;

  logic                 w_accept;
  logic                 w_capture;
  logic [CHANNEL_NUM-1:0] w_mask;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_hit;
  logic                 w_miss;
  logic                 w_pop;
  logic                 w_fifo_valid;
  logic [c_RES_W-1:0]   w_fifo_rdata;
  logic [c_FCNT_W-1:0]  w_fifo_count;

  // Space is reserved at accept time: a full FIFO blocks new descriptors.
  // r_rdy_en holds ready low for the cycle right after reset.
  assign o_pkt_ready = r_rdy_en && (r_state == ST_IDLE) && (w_fifo_count < c_FIFO_FULL);
  assign w_accept    = i_pkt_valid && o_pkt_ready;

  // Table data is sampled on the last WAIT cycle, LKP_LAT cycles after the read strobe
  assign w_capture = (r_state == ST_WAIT) && (r_lat_cnt == '0);
  assign w_mask    = i_fwd_data[c_MASK_MSB:TAG_W];
  assign w_tag     = i_fwd_data[FWD_TAG_MSB:0];
  assign w_hit     = w_capture && (w_mask != '0);
  assign w_miss    = w_capture && (w_mask == '0);
  assign w_pop     = w_fifo_valid && i_res_ready;

  // Lookup sequencer: one lookup in flight; read strobe and address are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rdy_en   <= 1'b0;
      r_fwd_rden <= 1'b0;
      r_fwd_addr <= '0;
      r_id       <= '0;
      r_lat_cnt  <= '0;
    end else begin
      r_rdy_en   <= 1'b1;
      r_fwd_rden <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_id       <= i_pkt_id;
            r_fwd_addr <= i_pkt_key;
            r_fwd_rden <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_lat_cnt <= c_LAT_LOAD;
          r_state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) r_state <= ST_IDLE;
          else                 r_lat_cnt <= r_lat_cnt - c_LAT_W'(1);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Hit and drop statistics, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_hit)  r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (w_miss) r_drop_cnt <= sat_inc(r_drop_cnt);
    end
  end

  fwd_res_fifo #(
    .WIDTH (c_RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_hit),
    .i_wdata ({r_id, w_mask, w_tag}),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count)
  );

  assign o_fwd_rden  = r_fwd_rden;
  assign o_fwd_addr  = r_fwd_addr;
  assign o_res_valid = w_fifo_valid;
  assign {o_res_id, o_res_mask, o_res_tag} = w_fifo_rdata;
  assign o_hit_cnt   = r_hit_cnt;
  assign o_drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_lkp_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fwd_lkp_engine
//  Brief    : Scoreboard bench for fwd_lkp_engine at LKP_LAT=1 and LKP_LAT=3
//  Revision : 1.0
// ============================================================================
module tb_fwd_lkp_engine;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        pkt_valid [2];
  logic        pkt_ready [2];
  logic [7:0]  pkt_key   [2];
  logic [7:0]  pkt_id    [2];
  logic        fwd_rden  [2];
  logic [7:0]  fwd_addr  [2];
  logic [15:0] fwd_data  [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [7:0]  res_id    [2];
  logic [3:0]  res_mask  [2];
  logic [11:0] res_tag   [2];
  logic [15:0] hit_cnt   [2];
  logic [15:0] drop_cnt  [2];

  fwd_lkp_engine #(.CHANNEL_NUM(4), .ID_W(8), .LKP_LAT(LAT0), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .i_pkt_valid(pkt_valid[0]), .o_pkt_ready(pkt_ready[0]),
    .i_pkt_key(pkt_key[0]), .i_pkt_id(pkt_id[0]),
    .o_fwd_rden(fwd_rden[0]), .o_fwd_addr(fwd_addr[0]), .i_fwd_data(fwd_data[0]),
    .o_res_valid(res_valid[0]), .i_res_ready(res_ready[0]),
    .o_res_id(res_id[0]), .o_res_mask(res_mask[0]), .o_res_tag(res_tag[0]),
    .o_hit_cnt(hit_cnt[0]), .o_drop_cnt(drop_cnt[0])
  );

  fwd_lkp_engine #(.CHANNEL_NUM(4), .ID_W(8), .LKP_LAT(LAT1), .FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .i_pkt_valid(pkt_valid[1]), .o_pkt_ready(pkt_ready[1]),
    .i_pkt_key(pkt_key[1]), .i_pkt_id(pkt_id[1]),
    .o_fwd_rden(fwd_rden[1]), .o_fwd_addr(fwd_addr[1]), .i_fwd_data(fwd_data[1]),
    .o_res_valid(res_valid[1]), .i_res_ready(res_ready[1]),
    .o_res_id(res_id[1]), .o_res_mask(res_mask[1]), .o_res_tag(res_tag[1]),
    .o_hit_cnt(hit_cnt[1]), .o_drop_cnt(drop_cnt[1])
  );

  // Forwarding table model: registered read with LAT stages; garbage when not read
  logic [15:0] tbl   [256];
  logic [15:0] pipe0 [3];
  logic [15:0] pipe1 [3];

  always @(posedge clk) begin
    pipe0[0] <= fwd_rden[0] ? tbl[fwd_addr[0]] : 16'($urandom);
    pipe0[1] <= pipe0[0];
    pipe0[2] <= pipe0[1];
    pipe1[0] <= fwd_rden[1] ? tbl[fwd_addr[1]] : 16'($urandom);
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign fwd_data[0] = pipe0[LAT0-1];
  assign fwd_data[1] = pipe1[LAT1-1];

  // Scoreboard state
  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [15:0] exp_hit  [2];
  logic [15:0] exp_drop [2];
  int          popped   [2];
  int          n_checks = 0;
  int          n_errs   = 0;

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour: a hit (non-zero mask) yields one result in order, a miss only counts
  task automatic model_accept(input int i, input logic [7:0] key, input logic [7:0] id);
    logic [15:0] e;
    e = tbl[key];
    if (e[15:12] != 4'd0) begin
      if (i == 0) q0.push_back({id, e});
      else        q1.push_back({id, e});
      exp_hit[i] = sat16(exp_hit[i]);
    end else begin
      exp_drop[i] = sat16(exp_drop[i]);
    end
  endtask

  // Monitor: every consumed result must match the oldest outstanding expectation
  always @(negedge clk) begin
    logic [23:0] got;
    logic [23:0] want;
    for (int i = 0; i < 2; i++) begin
      if (!rst[i] && res_valid[i] && res_ready[i]) begin
        got = {res_id[i], res_mask[i], res_tag[i]};
        if (qsize(i) == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_result[%0d]: got %h expected none pending", i, got);
        end else begin
          want = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("result[%0d]", i), {8'h0, got}, {8'h0, want});
        end
        popped[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a descriptor for at most max_wait cycles; called and returns at posedge+1
  task automatic send(input int i, input logic [7:0] key, input logic [7:0] id,
                      input int max_wait, input bit randrr, output bit acc);
    acc = 1'b0;
    pkt_valid[i] = 1'b1;
    pkt_key[i]   = key;
    pkt_id[i]    = id;
    for (int w = 0; w < max_wait && !acc; w++) begin
      if (randrr) res_ready[i] = ($urandom_range(0, 3) != 0);
      if (pkt_ready[i]) begin
        acc = 1'b1;
        model_accept(i, key, id);
      end
      tick(1);
    end
    pkt_valid[i] = 1'b0;
    pkt_key[i]   = 8'($urandom);
    pkt_id[i]    = 8'($urandom);
  endtask

  task automatic drain(input int i, input string name);
    res_ready[i] = 1'b1;
    for (int w = 0; w < 200; w++) begin
      if (qsize(i) == 0 && !res_valid[i] && pkt_ready[i]) break;
      tick(1);
    end
    chk($sformatf("%s_drained[%0d]", name, i), {31'd0, (qsize(i) == 0 && !res_valid[i])}, 32'd1);
  endtask

  task automatic chk_cnt(input int i, input string name);
    chk($sformatf("%s_hit_cnt[%0d]", name, i),  {16'd0, hit_cnt[i]},  {16'd0, exp_hit[i]});
    chk($sformatf("%s_drop_cnt[%0d]", name, i), {16'd0, drop_cnt[i]}, {16'd0, exp_drop[i]});
  endtask

  task force_drop(input int i);
    if (i == 0) force u_dut0.r_drop_cnt = 16'hFFFE;
    else        force u_dut1.r_drop_cnt = 16'hFFFE;
    tick(1);
    if (i == 0) release u_dut0.r_drop_cnt;
    else        release u_dut1.r_drop_cnt;
    exp_drop[i] = 16'hFFFE;
  endtask

  task automatic run_all(input int i, input int lat);
    bit acc;
    int n_acc;
    int p0;

    // Single hit with exact timing
    res_ready[i] = 1'b1;
    send(i, 8'h05, 8'h11, 10, 1'b0, acc);
    chk($sformatf("s1_accept[%0d]", i), {31'd0, acc}, 32'd1);
    chk($sformatf("s1_rden[%0d]", i), {31'd0, fwd_rden[i]}, 32'd1);
    chk($sformatf("s1_addr[%0d]", i), {24'd0, fwd_addr[i]}, 32'h05);
    tick(1);
    chk($sformatf("s1_rden_pulse[%0d]", i), {31'd0, fwd_rden[i]}, 32'd0);
    tick(lat - 1);
    chk($sformatf("s1_early_valid[%0d]", i), {31'd0, res_valid[i]}, 32'd0);
    tick(1);
    chk($sformatf("s1_valid[%0d]", i), {31'd0, res_valid[i]}, 32'd1);
    chk($sformatf("s1_res[%0d]", i), {8'd0, res_id[i], res_mask[i], res_tag[i]}, 32'h0011_3ABC);
    tick(1);
    chk($sformatf("s1_hit_cnt[%0d]", i), {16'd0, hit_cnt[i]}, 32'd1);
    chk_cnt(i, "s1");

    // Miss: dropped, counted, ready returns after LAT+2 cycles
    send(i, 8'h07, 8'h22, 10, 1'b0, acc);
    tick(lat);
    chk($sformatf("s2_ready_busy[%0d]", i), {31'd0, pkt_ready[i]}, 32'd0);
    tick(1);
    chk($sformatf("s2_ready_back[%0d]", i), {31'd0, pkt_ready[i]}, 32'd1);
    chk($sformatf("s2_no_result[%0d]", i), {31'd0, res_valid[i]}, 32'd0);
    chk($sformatf("s2_drop_cnt[%0d]", i), {16'd0, drop_cnt[i]}, 32'd1);
    chk_cnt(i, "s2");

    // Backpressure: only FIFO_DEPTH descriptors fit while results are stalled
    res_ready[i] = 1'b0;
    p0 = popped[i];
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      send(i, 8'(16 + k), 8'(8'h30 + k), 3 * (lat + 2) + 4, 1'b0, acc);
      if (acc) n_acc++;
    end
    chk($sformatf("s3_accepted[%0d]", i), n_acc, 32'd4);
    chk($sformatf("s3_ready_low[%0d]", i), {31'd0, pkt_ready[i]}, 32'd0);
    res_ready[i] = 1'b1;
    for (int k = 4; k < 6; k++) begin
      send(i, 8'(16 + k), 8'(8'h30 + k), 40, 1'b0, acc);
      chk($sformatf("s3_late_accept[%0d]", i), {31'd0, acc}, 32'd1);
    end
    drain(i, "s3");
    chk($sformatf("s3_popped[%0d]", i), popped[i] - p0, 32'd6);

    // Push and pop in the same cycle
    res_ready[i] = 1'b0;
    p0 = popped[i];
    send(i, 8'd24, 8'h40, 10, 1'b0, acc);
    tick(lat + 1);
    chk($sformatf("s4_first_held[%0d]", i), {31'd0, res_valid[i]}, 32'd1);
    send(i, 8'd25, 8'h41, 10, 1'b0, acc);
    chk($sformatf("s4_accept[%0d]", i), {31'd0, acc}, 32'd1);
    tick(lat);
    res_ready[i] = 1'b1;
    tick(1);
    res_ready[i] = 1'b0;
    chk($sformatf("s4_valid_after[%0d]", i), {31'd0, res_valid[i]}, 32'd1);
    chk($sformatf("s4_head_id[%0d]", i), {24'd0, res_id[i]}, 32'h41);
    drain(i, "s4");
    chk($sformatf("s4_popped[%0d]", i), popped[i] - p0, 32'd2);

    // Randomized traffic with random result backpressure
    for (int k = 0; k < 40; k++) begin
      send(i, 8'($urandom), 8'($urandom), 60, 1'b1, acc);
      chk($sformatf("rand_accept[%0d]", i), {31'd0, acc}, 32'd1);
      tick($urandom_range(0, 2));
    end
    drain(i, "rand");
    chk_cnt(i, "rand");

    // Reset while a lookup is outstanding
    res_ready[i] = 1'b1;
    send(i, 8'd26, 8'h50, 10, 1'b0, acc);
    tick(1);
    rst[i] = 1'b1;
    tick(1);
    chk($sformatf("s5_ready[%0d]", i), {31'd0, pkt_ready[i]}, 32'd0);
    chk($sformatf("s5_rden[%0d]", i), {31'd0, fwd_rden[i]}, 32'd0);
    chk($sformatf("s5_valid[%0d]", i), {31'd0, res_valid[i]}, 32'd0);
    chk($sformatf("s5_addr[%0d]", i), {24'd0, fwd_addr[i]}, 32'd0);
    chk($sformatf("s5_hit[%0d]", i), {16'd0, hit_cnt[i]}, 32'd0);
    chk($sformatf("s5_drop[%0d]", i), {16'd0, drop_cnt[i]}, 32'd0);
    if (i == 0) q0.delete(); else q1.delete();
    exp_hit[i]  = 16'd0;
    exp_drop[i] = 16'd0;
    rst[i] = 1'b0;
    tick(lat + 3);
    chk($sformatf("s5_stale_ignored[%0d]", i), {31'd0, res_valid[i]}, 32'd0);
    send(i, 8'd27, 8'h51, 10, 1'b0, acc);
    chk($sformatf("s5_accept[%0d]", i), {31'd0, acc}, 32'd1);
    drain(i, "s5");
    chk_cnt(i, "s5");

    // Drop counter saturation
    force_drop(i);
    chk($sformatf("s6_preset[%0d]", i), {16'd0, drop_cnt[i]}, 32'hFFFE);
    for (int k = 0; k < 3; k++) begin
      send(i, 8'h07, 8'(8'h60 + k), 10, 1'b0, acc);
      tick(lat + 2);
      chk($sformatf("s6_drop[%0d]", i), {16'd0, drop_cnt[i]}, 32'hFFFF);
    end
    chk_cnt(i, "s6");
  endtask

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 256; k++) begin
      tbl[k] = 16'($urandom);
      if (k % 4 == 0) tbl[k][15:12] = 4'd0;
      if (k >= 16 && k < 32 && tbl[k][15:12] == 4'd0) tbl[k][15:12] = 4'b1000;
    end
    tbl[5] = {4'b0011, 12'hABC};
    tbl[7] = 16'h0123;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      pkt_valid[i] = 1'b0;
      pkt_key[i] = 8'd0;
      pkt_id[i] = 8'd0;
      res_ready[i] = 1'b0;
      exp_hit[i] = 16'd0;
      exp_drop[i] = 16'd0;
      popped[i] = 0;
    end
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready[%0d]", i), {31'd0, pkt_ready[i]}, 32'd0);
      chk($sformatf("reset_rden[%0d]", i), {31'd0, fwd_rden[i]}, 32'd0);
      chk($sformatf("reset_valid[%0d]", i), {31'd0, res_valid[i]}, 32'd0);
      chk($sformatf("reset_addr[%0d]", i), {24'd0, fwd_addr[i]}, 32'd0);
      chk_cnt(i, "reset");
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick(2);
    run_all(0, LAT0);
    run_all(1, LAT1);
    tick(2);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
